// File: rtl/fpu_pkg.sv
// fpu_pkg
// Shared types and constants for the FPU multiplier front end.
//   fp_class_t     : operand class as it leaves the unpacker
//   unpack_state_t : control states of the operand unpacker
//   FRAC_W/EXP_W   : IEEE-754 single stored field widths
//   XEXP_W         : widened, signed, biased exponent width used downstream
// Optional build macro: FP_UNPACK_FTZ_EN (flush subnormal operands to zero).
package fpu_pkg;

  localparam int FRAC_W   = 23;
  localparam int EXP_W    = 8;
  localparam int XEXP_W   = 10;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    ZERO   = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fp_class_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } unpack_state_t;

endpackage

// File: rtl/fp_class_decode.sv
// fp_class_decode
// Combinational field split and classification of one packed single operand.
// Ports:
//   op        in  32       packed IEEE-754 single
//   sign      out 1        sign bit
//   op_class  out 2        NORMAL / ZERO / INF / NAN
//   fraction  out FRAC_W+1 initial fraction, hidden bit at the MSB
//   exponent  out XEXP_W   initial biased exponent, zero-extended
//   subnormal out 1        operand still needs left-normalization
// Optional build macro: FP_UNPACK_FTZ_EN (subnormals decode as ZERO).
module fp_class_decode
  import fpu_pkg::*;
(
  input  logic [31:0]       op,
  output logic              sign,
  output fp_class_t         op_class,
  output logic [FRAC_W:0]   fraction,
  output logic [XEXP_W-1:0] exponent,
  output logic              subnormal
);

  logic [EXP_W-1:0]  exp_field;
  logic [FRAC_W-1:0] frac_field;

  assign sign       = op[31];
  assign exp_field  = op[FRAC_W +: EXP_W];
  assign frac_field = op[FRAC_W-1:0];

  // Default is an ordinary normal number; the special encodings override it.
  // A subnormal is loaded with exponent 1 and no hidden bit so that each
  // later left shift can simply decrement the exponent by one.
  always_comb begin
    op_class  = NORMAL;
    fraction  = {1'b1, frac_field};
    exponent  = {{(XEXP_W-EXP_W){1'b0}}, exp_field};
    subnormal = 1'b0;
    if (exp_field == EXP_W'(EXP_MAX)) begin
      exponent = XEXP_W'(EXP_MAX);
      if (frac_field != '0) begin
        op_class = NAN;
      end else begin
        op_class = INF;
        fraction = {1'b1, {FRAC_W{1'b0}}};
      end
    end else if (exp_field == '0) begin
      if (frac_field == '0) begin
        op_class = ZERO;
        fraction = '0;
        exponent = '0;
      end else begin
`ifdef FP_UNPACK_FTZ_EN
        op_class = ZERO;
        fraction = '0;
        exponent = '0;
`else
        fraction  = {1'b0, frac_field};
        exponent  = XEXP_W'(1);
        subnormal = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/fp_operand_unpacker.sv
// fp_operand_unpacker
// Front end of the FPU multiplier: captures two packed singles, classifies
// them and left-normalizes subnormals one bit per cycle so that both
// fractions leave with the leading one at bit FRAC_W.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    operand handshake (ready only while idle)
//   op_a, op_b             packed operands, sampled at accept only
//   out_valid / out_ready  result handshake, result held until accepted
//   a_/b_fraction          unpacked fractions, leading one at bit 23
//   a_/b_exponent          signed biased exponents (XEXP_W bits)
//   a_/b_class             0 NORMAL, 1 ZERO, 2 INF, 3 NAN
//   prod_sign              sign of the eventual product
// Optional build macro: FP_UNPACK_FTZ_EN (flush subnormals to zero, no NORM).
module fp_operand_unpacker
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       op_a,
  input  logic [31:0]       op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W:0]   a_fraction,
  output logic [XEXP_W-1:0] a_exponent,
  output logic [1:0]        a_class,
  output logic [FRAC_W:0]   b_fraction,
  output logic [XEXP_W-1:0] b_exponent,
  output logic [1:0]        b_class,
  output logic              prod_sign
);

  unpack_state_t state;

  logic              dec_a_sign, dec_b_sign;
  fp_class_t         dec_a_class, dec_b_class;
  logic [FRAC_W:0]   dec_a_fraction, dec_b_fraction;
  logic [XEXP_W-1:0] dec_a_exponent, dec_b_exponent;

`ifndef FP_UNPACK_FTZ_EN
  logic dec_a_subnormal, dec_b_subnormal;
  logic a_shift, b_shift;
  logic a_settled, b_settled;

  // Only a NORMAL-class operand without its leading one still shifts; ZERO
  // has an all-zero fraction and must never be shifted. "Settled" looks at
  // the fraction as it will be after this cycle's shift.
  assign a_shift   = (a_class == NORMAL) && !a_fraction[FRAC_W];
  assign b_shift   = (b_class == NORMAL) && !b_fraction[FRAC_W];
  assign a_settled = !a_shift || a_fraction[FRAC_W-1];
  assign b_settled = !b_shift || b_fraction[FRAC_W-1];
`endif

  fp_class_decode u_dec_a (
    .op        (op_a),
    .sign      (dec_a_sign),
    .op_class  (dec_a_class),
    .fraction  (dec_a_fraction),
    .exponent  (dec_a_exponent),
`ifdef FP_UNPACK_FTZ_EN
    .subnormal ()
`else
    .subnormal (dec_a_subnormal)
`endif
  );

  fp_class_decode u_dec_b (
    .op        (op_b),
    .sign      (dec_b_sign),
    .op_class  (dec_b_class),
    .fraction  (dec_b_fraction),
    .exponent  (dec_b_exponent),
`ifdef FP_UNPACK_FTZ_EN
    .subnormal ()
`else
    .subnormal (dec_b_subnormal)
`endif
  );

  // Control and datapath in one registered process. out_valid is raised on
  // the same edge that enters DONE, so a result that needs no shifting is
  // visible right after the accept edge and can be taken on the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      a_fraction <= '0;
      a_exponent <= '0;
      a_class    <= NORMAL;
      b_fraction <= '0;
      b_exponent <= '0;
      b_class    <= NORMAL;
      prod_sign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_fraction <= dec_a_fraction;
            a_exponent <= dec_a_exponent;
            a_class    <= dec_a_class;
            b_fraction <= dec_b_fraction;
            b_exponent <= dec_b_exponent;
            b_class    <= dec_b_class;
            prod_sign  <= dec_a_sign ^ dec_b_sign;
            in_ready   <= 1'b0;
`ifdef FP_UNPACK_FTZ_EN
            state      <= DONE;
            out_valid  <= 1'b1;
`else
            if (dec_a_subnormal || dec_b_subnormal) begin
              state <= NORM;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
`endif
          end
        end
`ifndef FP_UNPACK_FTZ_EN
        NORM: begin
          if (a_shift) begin
            a_fraction <= {a_fraction[FRAC_W-1:0], 1'b0};
            a_exponent <= a_exponent - XEXP_W'(1);
          end
          if (b_shift) begin
            b_fraction <= {b_fraction[FRAC_W-1:0], 1'b0};
            b_exponent <= b_exponent - XEXP_W'(1);
          end
          if (a_settled && b_settled) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_operand_unpacker.sv
// tb_fp_operand_unpacker
// Self-checking bench for fp_operand_unpacker: directed corner cases followed
// by randomized operand pairs, compared against an arithmetic reference model.
module tb_fp_operand_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] a_fraction, b_fraction;
  logic [9:0]  a_exponent, b_exponent;
  logic [1:0]  a_class, b_class;
  logic        prod_sign;

  int totalChecks = 0;
  int badChecks   = 0;

  fp_operand_unpacker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a_fraction (a_fraction),
    .a_exponent (a_exponent),
    .a_class    (a_class),
    .b_fraction (b_fraction),
    .b_exponent (b_exponent),
    .b_class    (b_class),
    .prod_sign  (prod_sign)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    totalChecks++;
    if (got !== want) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, want);
    end
  endtask

  // Reference model: classification from the field rules; subnormals are
  // normalized by locating the leading one arithmetically.
  function automatic void refModel(input logic [31:0] op, output logic [1:0] cls,
                                   output logic [23:0] frac, output logic [9:0] expo,
                                   output int shifts);
    int e, f, msb;
    e = int'(op[30:23]);
    f = int'(op[22:0]);
    shifts = 0;
    msb = 0;
    if (e == 255) begin
      cls  = (f != 0) ? 2'd3 : 2'd2;
      frac = (f != 0) ? 24'(f + 2**23) : 24'h800000;
      expo = 10'd255;
    end else if (e == 0 && f == 0) begin
      cls = 2'd1; frac = 24'd0; expo = 10'd0;
    end else if (e == 0) begin
`ifdef FP_UNPACK_FTZ_EN
      cls = 2'd1; frac = 24'd0; expo = 10'd0;
`else
      for (int i = 0; i < 23; i++) if (f >= (1 << i)) msb = i;
      shifts = 23 - msb;
      cls  = 2'd0;
      frac = 24'(f * (2**shifts));
      expo = 10'(1 - shifts);
`endif
    end else begin
      cls = 2'd0; frac = 24'(f + 2**23); expo = 10'(e);
    end
  endfunction

  task automatic checkFields(input logic [31:0] a, input logic [31:0] b);
    logic [1:0]  ca, cb;
    logic [23:0] fa, fb;
    logic [9:0]  ea, eb;
    int sa, sb;
    refModel(a, ca, fa, ea, sa);
    refModel(b, cb, fb, eb, sb);
    checkOutput("a_fraction", 32'(a_fraction), 32'(fa));
    checkOutput("a_exponent", 32'(a_exponent), 32'(ea));
    checkOutput("a_class",    32'(a_class),    32'(ca));
    checkOutput("b_fraction", 32'(b_fraction), 32'(fb));
    checkOutput("b_exponent", 32'(b_exponent), 32'(eb));
    checkOutput("b_class",    32'(b_class),    32'(cb));
    checkOutput("prod_sign",  32'(prod_sign),  32'(a[31] ^ b[31]));
  endtask

  // One full transaction starting just after a rising edge with the DUT idle.
  // Junk in_valid pulses are driven while busy; they must be ignored.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [1:0]  c;
    logic [23:0] f;
    logic [9:0]  e;
    int sa, sb, cycles;
    refModel(a, c, f, e, sa);
    refModel(b, c, f, e, sb);
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    cycles = 1;
    while (!out_valid && cycles < 40) begin
      checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
      in_valid = 1'($urandom); op_a = $urandom; op_b = $urandom;
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("latency", 32'(cycles), 32'((sa > sb ? sa : sb) + 1));
    checkFields(a, b);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom); op_a = $urandom; op_b = $urandom;
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkFields(a, b);
    end
    in_valid = 1'b1; op_a = $urandom; op_b = $urandom;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("post_valid", 32'(out_valid), 32'd0);
    checkOutput("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  function automatic logic [31:0] randOperand();
    logic [31:0] r;
    int kind;
    r = $urandom;
    kind = $urandom_range(0, 9);
    case (kind)
      0: r[30:0] = '0;
      1: begin r[30:23] = 8'hFF; r[22:0] = '0; end
      2: begin r[30:23] = 8'hFF; if (r[22:0] == '0) r[0] = 1'b1; end
      3, 4, 5: begin
        r[30:23] = 8'h00;
        r[22:0] = r[22:0] >> $urandom_range(0, 22);
        if (r[22:0] == '0) r[0] = 1'b1;
      end
      default: if (r[30:23] == 8'h00 || r[30:23] == 8'hFF) r[30:23] = 8'h01;
    endcase
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_a_fraction", 32'(a_fraction), 32'd0);
    checkOutput("rst_b_exponent", 32'(b_exponent), 32'd0);
    checkOutput("rst_a_class", 32'(a_class), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed cases");
    applyStimulus(32'h3FC00000, 32'hC0000000, 0);
    applyStimulus(32'h00000001, 32'h3F800000, 0);
    applyStimulus(32'h00400000, 32'h00200000, 0);
    applyStimulus(32'h7F800000, 32'h80000000, 0);
    applyStimulus(32'h7FC00001, 32'h80000000, 5);

    $display("[TB] reset during normalization");
    op_a = 32'h00000001; op_b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
`ifndef FP_UNPACK_FTZ_EN
    checkOutput("mid_norm_valid", 32'(out_valid), 32'd0);
`endif
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("arst_a_fraction", 32'(a_fraction), 32'd0);
    checkOutput("arst_a_exponent", 32'(a_exponent), 32'd0);
    checkOutput("arst_b_fraction", 32'(b_fraction), 32'd0);
    checkOutput("arst_prod_sign", 32'(prod_sign), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    applyStimulus(32'h3FC00000, 32'hC0000000, 0);

    $display("[TB] randomized cases");
    for (int n = 0; n < 200; n++) begin
      applyStimulus(randOperand(), randOperand(), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
